// File: rtl/alu_frame_master_pkg.sv
// Shared definitions for the ALU frame master and the UART-side ALU responder.
// Holds default data width, frame sync byte, frame byte order and FSM state encoding.
package alu_frame_master_pkg;

  localparam int         DEF_NB_DATA   = 8;
  localparam logic [7:0] DEF_START_FSM = 8'hFF;

  // Request frame byte order on the wire: sync, operand A, operand B, opcode.
  localparam int FRAME_LEN     = 4;
  localparam int FRAME_IDX_SYN = 0;
  localparam int FRAME_IDX_A   = 1;
  localparam int FRAME_IDX_B   = 2;
  localparam int FRAME_IDX_OP  = 3;

  // One-hot master FSM states.
  typedef enum logic [6:0] {
    IDLE      = 7'b000_0001,
    SEND_SYNC = 7'b000_0010,
    SEND_A    = 7'b000_0100,
    SEND_B    = 7'b000_1000,
    SEND_OP   = 7'b001_0000,
    WAIT_RES  = 7'b010_0000,
    RESP      = 7'b100_0000
  } state_t;

endpackage

// File: rtl/alu_frame_master_if.sv
// Bus bundle for the ALU frame master: request handshake, UART TX FIFO push side,
// UART RX FIFO pop side (first-word-fall-through) and response handshake.
// master: the frame master itself. slave: the surrounding request source, FIFOs
// and response consumer.
interface alu_frame_master_if
  import alu_frame_master_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA
);
  logic               req_valid;
  logic               req_ready;
  logic [NB_DATA-1:0] req_a;
  logic [NB_DATA-1:0] req_b;
  logic [NB_DATA-3:0] req_op;
  logic               tx_full;
  logic               wr_tx;
  logic [NB_DATA-1:0] data_tx;
  logic [NB_DATA-1:0] data_rx;
  logic               empty_rx;
  logic               rd;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [NB_DATA-1:0] rsp_data;
  logic               rsp_timeout;

  modport master (
    input  req_valid, req_a, req_b, req_op, tx_full, data_rx, empty_rx, rsp_ready,
    output req_ready, wr_tx, data_tx, rd, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    output req_valid, req_a, req_b, req_op, tx_full, data_rx, empty_rx, rsp_ready,
    input  req_ready, wr_tx, data_tx, rd, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/alu_frame_master_timeout_counter.sv
// Response timeout counter.
// clk/reset: clock and synchronous active-high reset.
// clear: zero the count (held while the master is outside WAIT_RES).
// en: count one more empty cycle. done: count has reached TERM.
// The count saturates at all-ones so a long stall can never wrap back to TERM.
module timeout_counter #(
  parameter int         W    = 16,
  parameter logic [W-1:0] TERM = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic done
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)          count <= '0;
    else if (en && (count != '1)) count <= count + 1'b1;
  end

  assign done = (count == TERM);
endmodule

// File: rtl/alu_frame_master.sv
// ALU frame master: takes an operand request, sends the frame
// {START_FSM, A, B, {2'b00,op}} into the UART TX FIFO, waits for one result byte
// in the RX FIFO (or a timeout) and presents it as a held response.
// Ports: clk, reset (sync, active high); bus (master modport) carries the request,
// TX FIFO, RX FIFO and response signals.
module alu_frame_master
  import alu_frame_master_pkg::*;
#(
  parameter int                 NB_DATA        = DEF_NB_DATA,
  parameter logic [NB_DATA-1:0] START_FSM      = NB_DATA'(DEF_START_FSM),
  parameter int                 NB_TIMEOUT     = 16,
  parameter int                 TIMEOUT_CYCLES = 50000
) (
  input logic               clk,
  input logic               reset,
  alu_frame_master_if.master bus
);
  localparam logic [NB_TIMEOUT-1:0] TMO_TERM = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t             state, state_next;
  logic [NB_DATA-1:0] a_q, b_q, rsp_data_q, data_tx;
  logic [NB_DATA-3:0] op_q;
  logic               rsp_timeout_q;
  logic               load, capture, expire, tmo_done;
  logic               req_ready, wr_tx, rd, rsp_valid;

  timeout_counter #(.W(NB_TIMEOUT), .TERM(TMO_TERM)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clear (state != WAIT_RES),
    .en    ((state == WAIT_RES) && bus.empty_rx),
    .done  (tmo_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    wr_tx      = 1'b0;
    data_tx    = '0;
    rd         = 1'b0;
    rsp_valid  = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        rd        = !bus.empty_rx;  // drop stale bytes from an earlier aborted frame
        if (bus.req_valid) begin
          load       = 1'b1;
          state_next = SEND_SYNC;
        end
      end
      SEND_SYNC: begin
        data_tx = START_FSM;
        wr_tx   = !bus.tx_full;
        if (!bus.tx_full) state_next = SEND_A;
      end
      SEND_A: begin
        data_tx = a_q;
        wr_tx   = !bus.tx_full;
        if (!bus.tx_full) state_next = SEND_B;
      end
      SEND_B: begin
        data_tx = b_q;
        wr_tx   = !bus.tx_full;
        if (!bus.tx_full) state_next = SEND_OP;
      end
      SEND_OP: begin
        data_tx = {2'b00, op_q};
        wr_tx   = !bus.tx_full;
        if (!bus.tx_full) state_next = WAIT_RES;
      end
      WAIT_RES: begin
        rd = !bus.empty_rx;
        // A byte arriving on the terminal-count cycle takes priority over the abort.
        if (!bus.empty_rx) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (tmo_done) begin
          expire     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      req_ready = 1'b0;
      wr_tx     = 1'b0;
      data_tx   = '0;
      rd        = 1'b0;
      rsp_valid = 1'b0;
      load      = 1'b0;
      capture   = 1'b0;
      expire    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (load) begin
        a_q  <= bus.req_a;
        b_q  <= bus.req_b;
        op_q <= bus.req_op;
      end
      if (capture) begin
        rsp_data_q    <= bus.data_rx;
        rsp_timeout_q <= 1'b0;
      end else if (expire) begin
        rsp_data_q    <= '0;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.wr_tx       = wr_tx;
  assign bus.data_tx     = data_tx;
  assign bus.rd          = rd;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_data    = reset ? '0 : rsp_data_q;
  assign bus.rsp_timeout = reset ? 1'b0 : rsp_timeout_q;
endmodule

// File: tb/tb_alu_frame_master.sv
// Bench for alu_frame_master: TX FIFO sink and RX FIFO source models, an
// ALU responder that answers each complete 4-byte frame, directed boundary
// frames followed by randomized frames, all judged against frame-level
// expectations (sent bytes, result byte, latency).
module tb_alu_frame_master;
  import alu_frame_master_pkg::*;

  localparam int NB  = 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_frame_master_if #(.NB_DATA(NB)) bus ();

  alu_frame_master #(
    .NB_DATA(NB), .START_FSM(8'hFF), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Environment FIFO models.
  logic [7:0] tx_q[$];
  logic [7:0] rx_mem[16];
  int         rx_wp = 0, rx_rp = 0;
  int         frame_n = 0, bad_push = 0, bad_pop = 0;
  logic       inj_vld, resp_on;
  logic [7:0] inj_byte, resp_byte;

  assign bus.empty_rx = (rx_wp == rx_rp);
  assign bus.data_rx  = rx_mem[rx_rp[3:0]];

  always @(posedge clk) begin
    if (bus.wr_tx && bus.tx_full) bad_push <= bad_push + 1;
    if (bus.wr_tx && !bus.tx_full) tx_q.push_back(bus.data_tx);
    if (reset) frame_n <= 0;
    else if (bus.wr_tx && !bus.tx_full) frame_n <= (frame_n == FRAME_LEN - 1) ? 0 : frame_n + 1;
    if (inj_vld) begin
      rx_mem[rx_wp[3:0]] <= inj_byte;
      rx_wp <= rx_wp + 1;
    end else if (bus.wr_tx && !bus.tx_full && frame_n == FRAME_LEN - 1 && resp_on) begin
      rx_mem[rx_wp[3:0]] <= resp_byte;
      rx_wp <= rx_wp + 1;
    end
    if (bus.rd) begin
      if (rx_wp == rx_rp) bad_pop <= bad_pop + 1;
      else rx_rp <= rx_rp + 1;
    end
  end

  function automatic logic [7:0] alu_ref(input logic [7:0] a, b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One request/response transaction. stall_*: forced tx_full window (cycles
  // after acceptance), inj_k: cycle in which a late result byte is injected,
  // exp_lat: expected cycle of first rsp_valid (0 = not checked).
  task automatic run_frame(input logic [7:0] a, b, input logic [5:0] op,
                           input int full_pct, stall_at, stall_len,
                           input bit respond, input int rdy_delay, inj_k, exp_lat);
    logic [7:0] exp_tx[4];
    logic [7:0] exp_data;
    logic       exp_tmo;
    int         base, rsp_k;
    bit         in_stall;
    exp_tx = '{8'hFF, a, b, {2'b00, op}};
    if (respond) begin
      exp_data = alu_ref(a, b, op); exp_tmo = 1'b0;
    end else if (inj_k >= 0) begin
      exp_data = 8'h5A; exp_tmo = 1'b0;
    end else begin
      exp_data = 8'h00; exp_tmo = 1'b1;
    end
    resp_on   = respond;
    resp_byte = alu_ref(a, b, op);
    base      = tx_q.size();
    chk("accept_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_op = op;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rsp_k = -1;
    for (int k = 1; k < 200; k++) begin
      // Live operands wander; only the values captured at acceptance may be sent.
      bus.req_a = 8'($urandom); bus.req_b = 8'($urandom); bus.req_op = 6'($urandom);
      in_stall    = (k >= stall_at) && (k < stall_at + stall_len);
      bus.tx_full = in_stall || ($urandom_range(99) < full_pct);
      inj_vld     = (k == inj_k);
      inj_byte    = 8'h5A;
      #1;
      if (bus.tx_full) chk("full_no_wr", bus.wr_tx, 1'b0);
      if (in_stall && full_pct == 0) chk("stall_hold", bus.data_tx, exp_tx[stall_at - 1]);
      if (full_pct == 0 && stall_len == 0 && k <= 4) chk("wr_cycle", bus.wr_tx, 1'b1);
      if (full_pct == 0 && stall_len == 0 && respond && k == 5) chk("rd_cycle", bus.rd, 1'b1);
      if (bus.rsp_valid) begin rsp_k = k; break; end
      @(negedge clk);
    end
    inj_vld = 1'b0; bus.tx_full = 1'b0;
    chk("rsp_seen", rsp_k >= 0, 1'b1);
    if (exp_lat > 0) chk("rsp_latency", rsp_k, exp_lat);
    chk("tx_count", tx_q.size() - base, 4);
    for (int i = 0; i < 4; i++)
      chk("tx_byte", (base + i < tx_q.size()) ? {24'h0, tx_q[base + i]} : 32'hx, exp_tx[i]);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_timeout", bus.rsp_timeout, exp_tmo);
    for (int i = 0; i < rdy_delay; i++) begin
      bus.req_valid = 1'b1; bus.req_a = 8'($urandom); bus.req_op = 6'h20;
      @(negedge clk); #1;
      chk("hold_valid", bus.rsp_valid, 1'b1);
      chk("hold_data", bus.rsp_data, exp_data);
      chk("hold_tmo", bus.rsp_timeout, exp_tmo);
      chk("hold_not_ready", bus.req_ready, 1'b0);
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0; #1;
    chk("released", bus.rsp_valid, 1'b0);
    chk("back_idle", bus.req_ready, 1'b1);
    chk("no_extra_tx", tx_q.size() - base, 4);
  endtask

  int         base0;
  logic [5:0] ops[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h20};

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.tx_full = 1'b0; bus.rsp_ready = 1'b0;
    inj_vld = 1'b0; inj_byte = '0; resp_on = 1'b0; resp_byte = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_wr_tx", bus.wr_tx, 1'b0);
    chk("rst_rd", bus.rd, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_data_tx", bus.data_tx, 8'h00);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("idle_ready", bus.req_ready, 1'b1);
    chk("idle_tmo", bus.rsp_timeout, 1'b0);

    // Nominal frame and latency.
    run_frame(8'h12, 8'h34, 6'h20, 0, 0, 0, 1'b1, 0, -1, 6);
    // Three-cycle TX backpressure while B is pending.
    run_frame(8'h12, 8'h34, 6'h20, 0, 3, 3, 1'b1, 0, -1, 9);
    // No answer: abort after TMO empty cycles in WAIT_RES.
    run_frame(8'h55, 8'h66, 6'h22, 0, 0, 0, 1'b0, 0, -1, 13);
    // Result byte lands on the terminal-count cycle and wins.
    run_frame(8'h01, 8'h02, 6'h24, 0, 0, 0, 1'b0, 0, 11, 13);
    // Operands equal to the sync byte go out untouched.
    run_frame(8'hFF, 8'hFF, 6'h3F, 0, 0, 0, 1'b1, 0, -1, 6);

    // Stale RX bytes are drained in IDLE and do not leak into the response.
    resp_on = 1'b0;
    inj_byte = 8'hC3; inj_vld = 1'b1;
    @(negedge clk);
    inj_byte = 8'h3C;
    @(negedge clk);
    inj_vld = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("stale_drained", bus.empty_rx, 1'b1);
    run_frame(8'h20, 8'h07, 6'h22, 0, 0, 0, 1'b1, 0, -1, 6);

    // Consumer stalls the response for 5 cycles while a new request waits.
    run_frame(8'hA5, 8'h0F, 6'h26, 0, 0, 0, 1'b1, 5, -1, 6);

    // Reset while SEND_A is on the bus.
    base0 = tx_q.size();
    resp_on = 1'b1;
    bus.req_valid = 1'b1; bus.req_a = 8'hAB; bus.req_b = 8'hCD; bus.req_op = 6'h20;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk); #1;
    chk("sendA_wr", bus.wr_tx, 1'b1);
    chk("sendA_data", bus.data_tx, 8'hAB);
    reset = 1'b1; #1;
    chk("rst_mid_wr", bus.wr_tx, 1'b0);
    chk("rst_mid_ready", bus.req_ready, 1'b0);
    chk("rst_mid_data", bus.data_tx, 8'h00);
    @(negedge clk); #1;
    chk("rst_hold_wr", bus.wr_tx, 1'b0);
    reset = 1'b0; #1;
    chk("rst_release_ready", bus.req_ready, 1'b1);
    chk("rst_tx_count", tx_q.size() - base0, 1);
    run_frame(8'h0A, 8'h0B, 6'h25, 0, 0, 0, 1'b1, 0, -1, 6);

    // Randomized frames with random backpressure, answers and consumer delay.
    for (int n = 0; n < 25; n++) begin
      run_frame(8'($urandom), 8'($urandom), ops[$urandom_range(7)], 30, 0, 0,
                ($urandom_range(4) != 0), $urandom_range(3), -1, 0);
    end

    chk("no_push_when_full", bad_push, 0);
    chk("no_pop_when_empty", bad_pop, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_frame_master.md
ALU_FRAME_MASTER -- requirements
Module: alu_frame_master

Interface
REQ-001 Parameter NB_DATA, default 8, byte width of UART FIFO data and ALU operands.
REQ-002 Parameter START_FSM, default 8'hFF, sync byte that opens every request frame.
REQ-003 Parameter NB_TIMEOUT, default 16, width of the response timeout counter.
REQ-004 Parameter TIMEOUT_CYCLES, default 50000, empty-RX cycles tolerated in WAIT_RES before abort.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  request operands present.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_a / req_b  input  NB_DATA each  operands A and B.
REQ-010 req_op  input  NB_DATA-2  ALU opcode.
REQ-011 tx_full  input  1  UART TX FIFO full.
REQ-012 wr_tx  output  1  push data_tx into TX FIFO.
REQ-013 data_tx  output  NB_DATA  byte to transmit.
REQ-014 data_rx  input  NB_DATA  RX FIFO head, first-word-fall-through, valid while empty_rx=0.
REQ-015 empty_rx  input  1  RX FIFO empty.
REQ-016 rd  output  1  pop RX FIFO head.
REQ-017 rsp_valid  output  1  response available, held until rsp_ready.
REQ-018 rsp_ready  input  1  consumer takes response.
REQ-019 rsp_data  output  NB_DATA  ALU result byte (0 on timeout).
REQ-020 rsp_timeout  output  1  response is a timeout abort, qualified by rsp_valid.

Function
REQ-021 FSM states: IDLE, SEND_SYNC, SEND_A, SEND_B, SEND_OP, WAIT_RES, RESP; one-hot encoding.
REQ-022 IDLE: req_ready=1; rd=!empty_rx to drain stale RX bytes; on req_valid&&req_ready register req_a/req_b/req_op, go SEND_SYNC.
REQ-023 Operands stay frozen from acceptance until return to IDLE; input changes are ignored.
REQ-024 SEND_SYNC/SEND_A/SEND_B/SEND_OP: data_tx = START_FSM / A / B / {2'b00,op}; wr_tx=!tx_full; advance to next state only in a cycle with tx_full=0.
REQ-025 tx_full=1 stalls the current send state with wr_tx=0 and data_tx held; no byte is dropped or duplicated.
REQ-026 Operand values equal to START_FSM are sent unmodified (no escaping).
REQ-027 WAIT_RES: counter cleared on entry; rd=!empty_rx; on empty_rx=0 register data_rx, clear timeout flag, go RESP.
REQ-028 WAIT_RES with empty_rx=1: counter increments; when counter = TIMEOUT_CYCLES-1, go RESP with rsp_data=0, rsp_timeout=1.
REQ-029 Byte arriving in the same cycle the timeout expires wins: data captured, rsp_timeout=0.
REQ-030 RESP: rsp_valid=1, rsp_data/rsp_timeout stable; rd=0, wr_tx=0; on rsp_ready go IDLE.
REQ-031 req_ready=0 in every state other than IDLE; rd=0 in all send states.
REQ-032 Latency with tx_full=0 and result byte waiting: accept cycle 0, wr_tx cycles 1-4, rd cycle 5, rsp_valid cycle 6.
REQ-033 Counter width NB_TIMEOUT; saturates, never wraps.

Reset
REQ-034 While reset=1: state IDLE, operand/result registers 0, counter 0, rsp_timeout 0.
REQ-035 While reset=1: req_ready, wr_tx, rd, rsp_valid forced 0; data_tx and rsp_data 0.
REQ-036 Reset mid-frame abandons the frame; no further TX bytes; first cycle after release is IDLE.

Structure
REQ-037 Shared package holds NB_DATA, START_FSM, frame byte order and state localparams, common to this block and the UART-side ALU responder.
REQ-038 One sub-module, timeout_counter (clear, enable, terminal-count output); everything else inline.

Verification
REQ-039 Request A=8'h12,B=8'h34,op=6'h20, tx_full=0, RX returns 8'h46 -> TX sequence FF,12,34,20; rd cycle 5; rsp_valid cycle 6 with rsp_data=8'h46, rsp_timeout=0.
REQ-040 tx_full high 3 cycles during SEND_B -> exactly four wr_tx pulses total, B=34 sent once after tx_full drops.
REQ-041 RX never returns, TIMEOUT_CYCLES=8 -> rsp_valid with rsp_data=0, rsp_timeout=1 after 8 WAIT_RES cycles.
REQ-042 Two stale bytes in RX FIFO while IDLE -> both popped before request; response uses only post-frame byte.
REQ-043 Reset asserted in SEND_A -> wr_tx=0 immediately; after release req_ready=1 and new frame starts with FF.
REQ-044 rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, req_ready=0, new req_valid ignored.
